mtr_drv: RTL and testbench

Motor drive stage for the Segway datapath: consumes the signed wheel speed commands `lft_spd`/`rght_spd` produced by the balance controller and generates dead-time-protected H-bridge PWM pairs for the left and right motors. Duty is latched once per PWM period. An optional over-current monitor latches a shutdown after repeated faults.

---
 rtl/mtr_pkg.sv | 23 ++
 rtl/pwm_dt.sv | 46 ++++
 rtl/mtr_drv.sv | 119 +++++++++++
 tb/tb_mtr_drv.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types, constants and the speed-to-duty mapping for the motor drive stage.
package mtr_pkg;

  localparam int PWM_W = 11;

  typedef logic [PWM_W-1:0] duty_t;

  localparam duty_t              MID_DUTY = 11'd1024;
  localparam logic signed [11:0] SPD_SAT  = 12'sd1023;

  // Clamp to +/-SPD_SAT, then offset so that 1024 is zero torque (range 1..2047).
  function automatic duty_t spd_to_duty(input logic signed [11:0] spd);
    logic signed [11:0] sat;
    if (spd > SPD_SAT)
      sat = SPD_SAT;
    else if (spd < -SPD_SAT)
      sat = -SPD_SAT;
    else
      sat = spd;
    return MID_DUTY + sat[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_dt.sv
// One motor side: registered high/low-side gate drive with dead time, plus the
// window in which that side's over-current flag is trusted.
module pwm_dt
  import mtr_pkg::*;
#(
  parameter int DEAD  = 32,
  parameter int BLANK = 64
) (
  input  logic  clk,
  input  logic  rst_n,
  input  duty_t cnt,
  input  duty_t duty,
  input  logic  en,
  output logic  pwm1,
  output logic  pwm2,
  output logic  ocq_win
);

  localparam int             QUAL   = DEAD + BLANK;
  localparam duty_t          DEAD_C = DEAD[PWM_W-1:0];
  localparam duty_t          QUAL_C = QUAL[PWM_W-1:0];
  localparam logic [PWM_W:0] DEAD_X = DEAD[PWM_W:0];

  // Low-side start is one bit wider so a late high-side fall pushes it past 2047.
  logic [PWM_W:0] pwm2_start;
  logic           pwm1_nxt;
  logic           pwm2_nxt;

  assign pwm2_start = {1'b0, duty} + DEAD_X;
  assign pwm1_nxt   = en && (cnt >= DEAD_C) && (cnt < duty);
  assign pwm2_nxt   = en && ({1'b0, cnt} >= pwm2_start);
  assign ocq_win    = (cnt >= QUAL_C) && (cnt < duty);

  // NOTE: non-blocking assignments make every flop sample the pre-edge cnt, which
  // is what gives the fixed one-clock lag between the compare and the gate drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm1 <= 1'b0;
      pwm2 <= 1'b0;
    end else begin
      pwm1 <= pwm1_nxt;
      pwm2 <= pwm2_nxt;
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// Motor drive stage: signed wheel speeds -> dead-time protected H-bridge PWM pairs.
// Define MTR_OVR_I_EN to build the over-current fault counter and shutdown latch.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter int DEAD      = 32,
  parameter int BLANK     = 64,
  parameter int OVR_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               lft_PWM1,
  output logic               lft_PWM2,
  output logic               rght_PWM1,
  output logic               rght_PWM2,
  output logic               PWM_synch,
  output logic               ovr_shtdwn
);

  duty_t cnt;
  duty_t duty_lft;
  duty_t duty_rght;
  logic  en_lat;
  logic  prd_end;
  logic  kill;
  logic  drv_en;
  logic  ocq_lft;
  logic  ocq_rght;

  assign prd_end = (cnt == '1);
  assign drv_en  = en_lat && !kill;

  // Duty and enable only move at the period boundary so a pulse is never cut short.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      duty_lft  <= MID_DUTY;
      duty_rght <= MID_DUTY;
      en_lat    <= 1'b0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      PWM_synch <= (cnt == '0);
      if (prd_end) begin
        duty_lft  <= spd_to_duty(lft_spd);
        duty_rght <= spd_to_duty(rght_spd);
        en_lat    <= en;
      end
    end
  end

  pwm_dt #(.DEAD(DEAD), .BLANK(BLANK)) u_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (cnt),
    .duty    (duty_lft),
    .en      (drv_en),
    .pwm1    (lft_PWM1),
    .pwm2    (lft_PWM2),
    .ocq_win (ocq_lft)
  );

  pwm_dt #(.DEAD(DEAD), .BLANK(BLANK)) u_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (cnt),
    .duty    (duty_rght),
    .en      (drv_en),
    .pwm1    (rght_PWM1),
    .pwm2    (rght_PWM2),
    .ocq_win (ocq_rght)
  );

`ifdef MTR_OVR_I_EN
  localparam int FLT_W  = $clog2(OVR_LIMIT + 1);
  localparam int LIM_M1 = OVR_LIMIT - 1;

  logic [FLT_W-1:0] flt_cnt;
  logic             prd_flt;
  logic             trip;

  // Trip is known during cnt==2047, so the gate drive is killed on the same edge
  // that sets the latch.
  assign trip = prd_end && prd_flt && (flt_cnt >= LIM_M1[FLT_W-1:0]);
  assign kill = ovr_shtdwn || trip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_cnt    <= '0;
      prd_flt    <= 1'b0;
      ovr_shtdwn <= 1'b0;
    end else begin
      if (prd_end) begin
        prd_flt <= 1'b0;
        if (!prd_flt)
          flt_cnt <= '0;
        else if (flt_cnt != OVR_LIMIT[FLT_W-1:0])
          flt_cnt <= flt_cnt + 1'b1;
      end else if ((OVR_I_lft && ocq_lft) || (OVR_I_rght && ocq_rght)) begin
        prd_flt <= 1'b1;
      end
      if (trip)
        ovr_shtdwn <= 1'b1;
    end
  end
`else
  logic unused_ovr;

  assign kill       = 1'b0;
  assign ovr_shtdwn = 1'b0;
  assign unused_ovr = ^{OVR_I_lft, OVR_I_rght, ocq_lft, ocq_rght, OVR_LIMIT[0]};
`endif

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: captures whole PWM periods and checks pulse
// extents, dead time, latching, disable, reset and over-current behaviour.
module tb_mtr_drv;

`ifdef MTR_OVR_I_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               OVR_I_lft;
  logic               OVR_I_rght;
  logic               lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2;
  logic               PWM_synch;
  logic               ovr_shtdwn;

  int ncmp = 0;
  int nfail = 0;
  int mcnt = 0;

  int pend_en, pend_lft, pend_rght;
  int ovr_at_l, ovr_at_r;

  logic [2047:0] cap_l1, cap_l2, cap_r1, cap_r2, cap_sy;
  logic          sd_end;

  mtr_drv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lft_spd    (lft_spd),
    .rght_spd   (rght_spd),
    .OVR_I_lft  (OVR_I_lft),
    .OVR_I_rght (OVR_I_rght),
    .lft_PWM1   (lft_PWM1),
    .lft_PWM2   (lft_PWM2),
    .rght_PWM1  (rght_PWM1),
    .rght_PWM2  (rght_PWM2),
    .PWM_synch  (PWM_synch),
    .ovr_shtdwn (ovr_shtdwn)
  );

  always #5 clk = ~clk;

  // Reference time base: the counter value present after each rising edge.
  always @(posedge clk) mcnt <= !rst_n ? 0 : (mcnt + 1) % 2048;

  function automatic void stats(input logic [2047:0] v, output int n, output int first,
                                output int last);
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 2048; k++) begin
      if (v[k]) begin
        n++;
        if (first < 0) first = k;
        last = k;
      end
    end
  endfunction

  task automatic wait_cnt(input int c);
    int guard;
    guard = 0;
    while (mcnt != c && guard < 4100) begin
      @(negedge clk);
      guard++;
    end
    if (mcnt != c) begin
      ncmp++;
      nfail++;
      $display("FAIL wait_cnt timeout got %0d want %0d", mcnt, c);
    end
  endtask

  // Records one period; sample idx k holds the outputs computed from cnt==k.
  task automatic capture(input int chg_at);
    int idx;
    wait_cnt(1);
    for (int i = 0; i < 2048; i++) begin
      idx = (mcnt + 2047) % 2048;
      cap_l1[idx] = lft_PWM1;
      cap_l2[idx] = lft_PWM2;
      cap_r1[idx] = rght_PWM1;
      cap_r2[idx] = rght_PWM2;
      cap_sy[idx] = PWM_synch;
      sd_end      = ovr_shtdwn;
      OVR_I_lft   = (mcnt == ovr_at_l);
      OVR_I_rght  = (mcnt == ovr_at_r);
      if (mcnt == chg_at) begin
        en       = pend_en[0];
        lft_spd  = 12'(pend_lft);
        rght_spd = 12'(pend_rght);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n, f, l;
    ncmp++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_shtdwn} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_outputs got %b want 000000",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_shtdwn});
    end
    pend_en = 1; pend_lft = 0; pend_rght = 2047;
    rst_n = 1'b1;
    capture(100);
    stats(cap_l1 | cap_l2 | cap_r1 | cap_r2, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL reset_period_disabled got %0d high want 0", n);
    end
    stats(cap_sy, n, f, l);
    ncmp++;
    if (n !== 1 || f !== 0) begin
      nfail++; $display("FAIL reset_synch got n=%0d at %0d want n=1 at 0", n, f);
    end
  endtask

  task automatic test_zero_sat();
    int n, f, l;
    pend_rght = -2048;
    capture(2047);
    stats(cap_l1, n, f, l);
    ncmp++;
    if (n !== 992 || f !== 32 || l !== 1023) begin
      nfail++; $display("FAIL zero_lft_pwm1 got %0d/%0d/%0d want 992/32/1023", n, f, l);
    end
    stats(cap_l2, n, f, l);
    ncmp++;
    if (n !== 992 || f !== 1056 || l !== 2047) begin
      nfail++; $display("FAIL zero_lft_pwm2 got %0d/%0d/%0d want 992/1056/2047", n, f, l);
    end
    ncmp++;
    if ((cap_l1 & cap_l2) !== '0) begin
      nfail++; $display("FAIL zero_overlap got overlap want none");
    end
    stats(cap_r1, n, f, l);
    ncmp++;
    if (n !== 2015 || f !== 32 || l !== 2046) begin
      nfail++; $display("FAIL sat_pos_rght_pwm1 got %0d/%0d/%0d want 2015/32/2046", n, f, l);
    end
    stats(cap_r2, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL sat_pos_rght_pwm2 got %0d high want 0", n);
    end
  endtask

  task automatic test_neg_sat();
    int n, f, l;
    capture(-1);
    stats(cap_r1, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL sat_neg_rght_pwm1 got %0d high want 0", n);
    end
    stats(cap_r2, n, f, l);
    ncmp++;
    if (n !== 2015 || f !== 33 || l !== 2047) begin
      nfail++; $display("FAIL sat_neg_rght_pwm2 got %0d/%0d/%0d want 2015/33/2047", n, f, l);
    end
  endtask

  task automatic test_mid_change();
    int n, f, l;
    pend_lft = 512;
    capture(500);
    stats(cap_l1, n, f, l);
    ncmp++;
    if (n !== 992 || f !== 32 || l !== 1023) begin
      nfail++; $display("FAIL mid_change_hold got %0d/%0d/%0d want 992/32/1023", n, f, l);
    end
    pend_lft = 1000; pend_rght = -1000;
    capture(2047);
    stats(cap_l1, n, f, l);
    ncmp++;
    if (n !== 1504 || f !== 32 || l !== 1535) begin
      nfail++; $display("FAIL mid_change_next_pwm1 got %0d/%0d/%0d want 1504/32/1535", n, f, l);
    end
    stats(cap_l2, n, f, l);
    ncmp++;
    if (n !== 480 || f !== 1568 || l !== 2047) begin
      nfail++; $display("FAIL mid_change_next_pwm2 got %0d/%0d/%0d want 480/1568/2047", n, f, l);
    end
  endtask

  task automatic test_boundary();
    int n, f, l;
    pend_lft = 0; pend_rght = 0;
    capture(2047);
    stats(cap_l1, n, f, l);
    ncmp++;
    if (n !== 1992 || f !== 32 || l !== 2023) begin
      nfail++; $display("FAIL late_fall_pwm1 got %0d/%0d/%0d want 1992/32/2023", n, f, l);
    end
    stats(cap_l2, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL late_fall_pwm2 got %0d high want 0", n);
    end
    stats(cap_r1, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL short_duty_pwm1 got %0d high want 0", n);
    end
    stats(cap_r2, n, f, l);
    ncmp++;
    if (n !== 1992 || f !== 56 || l !== 2047) begin
      nfail++; $display("FAIL short_duty_pwm2 got %0d/%0d/%0d want 1992/56/2047", n, f, l);
    end
  endtask

  task automatic test_disable();
    int n, f, l;
    pend_en = 0;
    capture(1000);
    stats(cap_l2, n, f, l);
    ncmp++;
    if (n !== 992 || f !== 1056 || l !== 2047) begin
      nfail++; $display("FAIL disable_hold_pwm2 got %0d/%0d/%0d want 992/1056/2047", n, f, l);
    end
    stats(cap_r1, n, f, l);
    ncmp++;
    if (n !== 992 || f !== 32 || l !== 1023) begin
      nfail++; $display("FAIL disable_hold_rght_pwm1 got %0d/%0d/%0d want 992/32/1023", n, f, l);
    end
    pend_en = 1;
    capture(2047);
    stats(cap_l1 | cap_l2 | cap_r1 | cap_r2, n, f, l);
    ncmp++;
    if (n !== 0) begin
      nfail++; $display("FAIL disable_outputs got %0d high want 0", n);
    end
    stats(cap_sy, n, f, l);
    ncmp++;
    if (n !== 1 || f !== 0) begin
      nfail++; $display("FAIL disable_synch got n=%0d at %0d want n=1 at 0", n, f);
    end
  endtask

  task automatic test_reset_mid();
    wait_cnt(700);
    ncmp++;
    if (lft_PWM1 !== 1'b1) begin
      nfail++; $display("FAIL reset_mid_pre got %b want 1", lft_PWM1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_shtdwn} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_mid_outputs got %b want 000000",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, ovr_shtdwn});
    end
    rst_n = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch} !== 5'b00001) begin
      nfail++;
      $display("FAIL reset_mid_restart got %b want 00001",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch});
    end
  endtask

  task automatic test_blanking();
    ovr_at_l = 40;
    for (int p = 0; p < 10; p++) begin
      capture(-1);
      ncmp++;
      if (sd_end !== 1'b0) begin
        nfail++; $display("FAIL blanking_period%0d got shtdwn=%b want 0", p, sd_end);
      end
    end
  endtask

  task automatic test_ovr_shutdown();
    int n, f, l;
    logic exp_sd;
    ovr_at_l = 200;
    for (int p = 0; p < 7; p++) begin
      capture(-1);
      ncmp++;
      if (sd_end !== 1'b0) begin
        nfail++; $display("FAIL fault7_period%0d got shtdwn=%b want 0", p, sd_end);
      end
    end
    ovr_at_l = -1;
    capture(-1);
    ncmp++;
    if (sd_end !== 1'b0) begin
      nfail++; $display("FAIL clean_period got shtdwn=%b want 0", sd_end);
    end
    ovr_at_l = 200;
    ovr_at_r = 200;
    for (int p = 0; p < 8; p++) begin
      capture(-1);
      exp_sd = OVR_EN && (p == 7);
      ncmp++;
      if (sd_end !== exp_sd) begin
        nfail++; $display("FAIL fault8_period%0d got shtdwn=%b want %b", p, sd_end, exp_sd);
      end
    end
    ncmp++;
    if ({cap_l2[2046], cap_l2[2047]} !== {1'b1, !OVR_EN}) begin
      nfail++;
      $display("FAIL trip_same_clock got %b%b want 1%b", cap_l2[2046], cap_l2[2047], !OVR_EN);
    end
    ovr_at_l = -1;
    ovr_at_r = -1;
    capture(-1);
    stats(cap_l1, n, f, l);
    ncmp++;
    if (n !== (OVR_EN ? 0 : 992)) begin
      nfail++; $display("FAIL post_trip_pwm1 got %0d high want %0d", n, OVR_EN ? 0 : 992);
    end
    ncmp++;
    if (sd_end !== OVR_EN) begin
      nfail++; $display("FAIL shtdwn_sticky got %b want %b", sd_end, OVR_EN);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lft_spd = '0; rght_spd = '0;
    OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
    ovr_at_l = -1; ovr_at_r = -1;
    pend_en = 0; pend_lft = 0; pend_rght = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_zero_sat();
    test_neg_sat();
    test_mid_change();
    test_boundary();
    test_disable();
    test_reset_mid();
    test_blanking();
    test_ovr_shutdown();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
